keymatrix: RTL and testbench
============================

Name: keymatrix

Overview:
- PS/2 set-2 scancode to TS2068 keyboard-matrix converter.
- Sits between the PS/2 byte receiver (strb/code) and the computer core (row/col), and also drives the tape play/stop and F5/F9 control strobes used at top level.
- Tracks E0/F0 prefixes, holds press state for 40 matrix keys plus composite keys, and answers the core's row scan.

Parameters:
- ROWS, 8, matrix rows (address lines A8..A15).
- COLS, 5, matrix columns (data bits D0..D4).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- strb   in  1  one-cycle pulse: code valid
- code   in  8  received PS/2 byte
- row    in  8  active-low row select from core (address high byte)
- col    out 5  active-low column data; 1 = no key
- play   out 1  active-low, F1 held
- stop   out 1  active-low, F2 held
- F5     out 1  active-low, F5 held (NMI request)
- F9     out 1  active-low, F9 held (reset request)

Behaviour:
- Reset (async, reset=1):
  - all 40 key bits = released (1)
  - composite bits cleared, prefix state = IDLE
  - col=5'h1F, play=stop=F5=F9=1
- Prefix FSM, advances only on strb. States IDLE, EXT, BRK, EXTBRK:
  - E0: IDLE→EXT, BRK→EXTBRK.
  - F0: IDLE→BRK, EXT→EXTBRK.
  - Any other byte: apply make (IDLE/EXT) or break (BRK/EXTBRK) with ext = (state is EXT or EXTBRK), then return to IDLE.
  - Unmapped codes change no key and still return to IDLE.
  - E1 is treated as unmapped.
- Matrix map, col bit0 first, active low:
  - r0 CS Z X C V
  - r1 A S D F G
  - r2 Q W E R T
  - r3 1 2 3 4 5
  - r4 0 9 8 7 6
  - r5 P O I U Y
  - r6 ENT L K J H
  - r7 SP SS M N B
- Physical CAPS SHIFT = L-shift 12 / R-shift 59. SYMBOL SHIFT = L-ctrl 14 / E0 14. Two sources per shifted key are ORed; each source holds its own bit.
- Composite keys, each with its own held bit:
  - Backspace 66 → CS+0
  - E0 6B left → CS+5
  - E0 72 down → CS+6
  - E0 75 up → CS+7
  - E0 74 right → CS+8
- Effective CS pressed = physical shift OR any composite held. Effective digit = its own key OR its composite.
- Releasing a composite never releases a physically held CS or digit.
- Column output is registered, 1-cycle latency:
  - col <= AND over r where row[r]=0 of effrow[r].
  - Multiple selected rows are ANDed.
  - row=FF gives col=1F.
- Make and break take effect in the cycle after strb. col reflects the change one further cycle later.
- Control keys (non-matrix, registered):
  - F1 05 → play
  - F2 06 → stop
  - F5 03 → F5
  - F9 01 → F9
- Repeated make codes (typematic) are idempotent.
- Break for a key not held: no change.
- Reset mid-sequence (after E0 or F0) returns to IDLE; the next byte is treated as unprefixed.
- strb during reset is ignored.

Optional Feature:
- KEYMATRIX_ESC_BREAK_EN
- Defined: Esc 76 is a sixth composite mapping to CS+SPACE (BREAK), same hold semantics as the other composites.
- Undefined: 76 is unmapped.

Decomposition:
- keymatrix_pkg holds:
  - prefix state enum
  - scancode constants (E0, F0, 12, 59, 14, 66, arrows, 01/03/05/06/76)
  - row/col index constants for CS, SS, SPACE and the digits 0/5/6/7/8
  - composite-key index enum
- One combinational sub-module, keymatrix_decode:
  - input: {ext, code}
  - outputs: valid, row index, col index, composite valid/index, control-key one-hot
- The top keeps the FSM, state registers and the scan register.

Test Plan:
- Make 1C (A), row=FD → col=1E. Then F0 1C → col=1F.
- Make E0 75 (up), row=FE → col=1E. row=EF → col=17. row=FE&EF=EE → col=16.
- Make 12 (shift), make 66 (backspace), break 66 → row=FE col=1E (CS still held), row=EF col=1F.
- Make 05 → play=0. F0 05 → play=1. Make 01 → F9=0.
- Send E0, assert reset, release, send 14 → SS set (row=7F → col=1D), not E0-ctrl path; after reset all outputs 1F/1.
- With KEYMATRIX_ESC_BREAK_EN: make 76, row=7F → col=1E, row=FE → col=1E. Without it: both col=1F.

Source files
------------

// File: rtl/keymatrix_pkg.sv
// Shared types and constants for the PS/2 to TS2068 keyboard matrix.
// KEYMATRIX_ESC_BREAK_EN adds Esc as a CS+SPACE composite.
package keymatrix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXTBRK
    } pfx_e;

    typedef enum logic [2:0] {
        CK_BKSP,
        CK_LEFT,
        CK_DOWN,
        CK_UP,
        CK_RIGHT,
        CK_ESC
    } comp_e;

`ifdef KEYMATRIX_ESC_BREAK_EN
    localparam int NCOMP = 6;
`else
    localparam int NCOMP = 5;
`endif

    localparam logic [7:0] SC_E0     = 8'hE0;
    localparam logic [7:0] SC_F0     = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_F9     = 8'h01;
    localparam logic [7:0] SC_F5     = 8'h03;
    localparam logic [7:0] SC_F1     = 8'h05;
    localparam logic [7:0] SC_F2     = 8'h06;
    localparam logic [7:0] SC_ESC    = 8'h76;

    localparam logic [2:0] CS_ROW = 3'd0, CS_COL = 3'd0;
    localparam logic [2:0] SS_ROW = 3'd7, SS_COL = 3'd1;
    localparam logic [2:0] SP_ROW = 3'd7, SP_COL = 3'd0;
    localparam logic [2:0] D0_ROW = 3'd4, D0_COL = 3'd0;
    localparam logic [2:0] D5_ROW = 3'd3, D5_COL = 3'd4;
    localparam logic [2:0] D6_ROW = 3'd4, D6_COL = 3'd4;
    localparam logic [2:0] D7_ROW = 3'd4, D7_COL = 3'd3;
    localparam logic [2:0] D8_ROW = 3'd4, D8_COL = 3'd2;

    localparam int CTL_PLAY = 0;
    localparam int CTL_STOP = 1;
    localparam int CTL_F5   = 2;
    localparam int CTL_F9   = 3;

    // Second matrix key pulled down by a composite, packed {row, col}
    function automatic logic [5:0] comp_target(input comp_e k);
        case (k)
            CK_BKSP:  comp_target = {D0_ROW, D0_COL};
            CK_LEFT:  comp_target = {D5_ROW, D5_COL};
            CK_DOWN:  comp_target = {D6_ROW, D6_COL};
            CK_UP:    comp_target = {D7_ROW, D7_COL};
            CK_RIGHT: comp_target = {D8_ROW, D8_COL};
            default:  comp_target = {SP_ROW, SP_COL};
        endcase
    endfunction

endpackage

// File: rtl/keymatrix_decode.sv
// Combinational scancode decoder: {ext, code} to matrix position,
// composite index or control key. Esc decodes only with KEYMATRIX_ESC_BREAK_EN.
module keymatrix_decode
    import keymatrix_pkg::*;
(
    input  logic       ext_i,
    input  logic [7:0] code_i,
    output logic       valid_o,
    output logic       alt_o,
    output logic [2:0] row_o,
    output logic [2:0] col_o,
    output logic       comp_valid_o,
    output comp_e      comp_o,
    output logic [3:0] ctl_o
);

    logic [5:0] rc;
    logic       hit;

    assign row_o   = rc[5:3];
    assign col_o   = rc[2:0];
    assign valid_o = hit;

    // rc is octal {row, col}; alt marks the second CS/SS source
    always_comb begin
        hit          = 1'b1;
        alt_o        = 1'b0;
        rc           = 6'o00;
        comp_valid_o = 1'b0;
        comp_o       = CK_BKSP;
        ctl_o        = 4'b0000;
        case ({ext_i, code_i})
            {1'b0, SC_LSHIFT}: rc = {CS_ROW, CS_COL};
            {1'b0, SC_RSHIFT}: begin alt_o = 1'b1; rc = {CS_ROW, CS_COL}; end
            9'h01A: rc = 6'o01;
            9'h022: rc = 6'o02;
            9'h021: rc = 6'o03;
            9'h02A: rc = 6'o04;
            9'h01C: rc = 6'o10;
            9'h01B: rc = 6'o11;
            9'h023: rc = 6'o12;
            9'h02B: rc = 6'o13;
            9'h034: rc = 6'o14;
            9'h015: rc = 6'o20;
            9'h01D: rc = 6'o21;
            9'h024: rc = 6'o22;
            9'h02D: rc = 6'o23;
            9'h02C: rc = 6'o24;
            9'h016: rc = 6'o30;
            9'h01E: rc = 6'o31;
            9'h026: rc = 6'o32;
            9'h025: rc = 6'o33;
            9'h02E: rc = 6'o34;
            9'h045: rc = 6'o40;
            9'h046: rc = 6'o41;
            9'h03E: rc = 6'o42;
            9'h03D: rc = 6'o43;
            9'h036: rc = 6'o44;
            9'h04D: rc = 6'o50;
            9'h044: rc = 6'o51;
            9'h043: rc = 6'o52;
            9'h03C: rc = 6'o53;
            9'h035: rc = 6'o54;
            9'h05A: rc = 6'o60;
            9'h04B: rc = 6'o61;
            9'h042: rc = 6'o62;
            9'h03B: rc = 6'o63;
            9'h033: rc = 6'o64;
            9'h029: rc = {SP_ROW, SP_COL};
            {1'b0, SC_CTRL}: rc = {SS_ROW, SS_COL};
            {1'b1, SC_CTRL}: begin alt_o = 1'b1; rc = {SS_ROW, SS_COL}; end
            9'h03A: rc = 6'o72;
            9'h031: rc = 6'o73;
            9'h032: rc = 6'o74;
            {1'b0, SC_BKSP}:  begin hit = 1'b0; comp_valid_o = 1'b1; comp_o = CK_BKSP;  end
            {1'b1, SC_LEFT}:  begin hit = 1'b0; comp_valid_o = 1'b1; comp_o = CK_LEFT;  end
            {1'b1, SC_DOWN}:  begin hit = 1'b0; comp_valid_o = 1'b1; comp_o = CK_DOWN;  end
            {1'b1, SC_UP}:    begin hit = 1'b0; comp_valid_o = 1'b1; comp_o = CK_UP;    end
            {1'b1, SC_RIGHT}: begin hit = 1'b0; comp_valid_o = 1'b1; comp_o = CK_RIGHT; end
`ifdef KEYMATRIX_ESC_BREAK_EN
            {1'b0, SC_ESC}:   begin hit = 1'b0; comp_valid_o = 1'b1; comp_o = CK_ESC;   end
`endif
            {1'b0, SC_F1}: begin hit = 1'b0; ctl_o[CTL_PLAY] = 1'b1; end
            {1'b0, SC_F2}: begin hit = 1'b0; ctl_o[CTL_STOP] = 1'b1; end
            {1'b0, SC_F5}: begin hit = 1'b0; ctl_o[CTL_F5]   = 1'b1; end
            {1'b0, SC_F9}: begin hit = 1'b0; ctl_o[CTL_F9]   = 1'b1; end
            default: hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/keymatrix.sv
// PS/2 set-2 to TS2068 keyboard matrix with prefix FSM and scan register.
// KEYMATRIX_ESC_BREAK_EN enables the Esc=CS+SPACE composite.
module keymatrix
    import keymatrix_pkg::*;
#(
    parameter int ROWS = 8,
    parameter int COLS = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            strb,
    input  logic [7:0]      code,
    input  logic [ROWS-1:0] row,
    output logic [COLS-1:0] col,
    output logic            play,
    output logic            stop,
    output logic            F5,
    output logic            F9
);

    pfx_e                       state_q, state_d;
    logic [ROWS-1:0][COLS-1:0]  keys_q, keys_d, eff;
    logic [1:0]                 alt_q, alt_d;
    logic [NCOMP-1:0]           comp_q, comp_d;
    logic [3:0]                 ctl_q, ctl_d;
    logic [COLS-1:0]            col_q, col_d;
    logic                       ext, brk;
    logic                       dec_valid, dec_alt, dec_cv;
    logic [2:0]                 dec_row, dec_col;
    comp_e                      dec_comp;
    logic [3:0]                 dec_ctl;
    logic [5:0]                 tgt;

    assign ext = (state_q == ST_EXT) || (state_q == ST_EXTBRK);
    assign brk = (state_q == ST_BRK) || (state_q == ST_EXTBRK);

    keymatrix_decode u_dec (
        .ext_i        (ext),
        .code_i       (code),
        .valid_o      (dec_valid),
        .alt_o        (dec_alt),
        .row_o        (dec_row),
        .col_o        (dec_col),
        .comp_valid_o (dec_cv),
        .comp_o       (dec_comp),
        .ctl_o        (dec_ctl)
    );

    always_comb begin
        state_d = state_q;
        keys_d  = keys_q;
        alt_d   = alt_q;
        comp_d  = comp_q;
        ctl_d   = ctl_q;
        if (strb) begin
            unique case (1'b1)
                code == SC_E0: state_d = brk ? ST_EXTBRK : ST_EXT;
                code == SC_F0: state_d = ext ? ST_EXTBRK : ST_BRK;
                default: begin
                    state_d = ST_IDLE;
                    if (dec_valid && dec_alt)
                        alt_d[dec_row == SS_ROW] = ~brk;
                    else if (dec_valid)
                        keys_d[dec_row][dec_col] = brk;
                    if (dec_cv)
                        comp_d[dec_comp] = ~brk;
                    ctl_d = brk ? (ctl_q & ~dec_ctl) : (ctl_q | dec_ctl);
                end
            endcase
        end
    end

    // Alternate sources and composites only ever pull bits low
    always_comb begin
        tgt = 6'o00;
        eff = keys_q;
        if (alt_q[0]) eff[CS_ROW][CS_COL] = 1'b0;
        if (alt_q[1]) eff[SS_ROW][SS_COL] = 1'b0;
        for (int i = 0; i < NCOMP; i++) begin
            if (comp_q[i]) begin
                tgt = comp_target(comp_e'(i));
                eff[CS_ROW][CS_COL] = 1'b0;
                eff[tgt[5:3]][tgt[2:0]] = 1'b0;
            end
        end
        col_d = '1;
        for (int r = 0; r < ROWS; r++)
            if (!row[r]) col_d = col_d & eff[r];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            keys_q  <= '1;
            alt_q   <= '0;
            comp_q  <= '0;
            ctl_q   <= '0;
            col_q   <= '1;
        end else begin
            state_q <= state_d;
            keys_q  <= keys_d;
            alt_q   <= alt_d;
            comp_q  <= comp_d;
            ctl_q   <= ctl_d;
            col_q   <= col_d;
        end
    end

    assign col  = col_q;
    assign play = ~ctl_q[CTL_PLAY];
    assign stop = ~ctl_q[CTL_STOP];
    assign F5   = ~ctl_q[CTL_F5];
    assign F9   = ~ctl_q[CTL_F9];

endmodule

// File: tb/tb_keymatrix.sv
// Randomized scoreboard bench for keymatrix against a key-set model.
// Honours KEYMATRIX_ESC_BREAK_EN for the Esc composite.
module tb_keymatrix;

    logic       clock = 1'b0;
    logic       reset;
    logic       strb;
    logic [7:0] code;
    logic [7:0] row;
    logic [4:0] col;
    logic       play, stop, F5, F9;

    keymatrix dut (
        .clock (clock),
        .reset (reset),
        .strb  (strb),
        .code  (code),
        .row   (row),
        .col   (col),
        .play  (play),
        .stop  (stop),
        .F5    (F5),
        .F9    (F9)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic [8:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Model: which {ext,code} keys are held, plus pending prefixes
    bit held[512];
    bit m_ext, m_brk;

    int mat[8][5] = '{
        '{'h12, 'h1A, 'h22, 'h21, 'h2A},
        '{'h1C, 'h1B, 'h23, 'h2B, 'h34},
        '{'h15, 'h1D, 'h24, 'h2D, 'h2C},
        '{'h16, 'h1E, 'h26, 'h25, 'h2E},
        '{'h45, 'h46, 'h3E, 'h3D, 'h36},
        '{'h4D, 'h44, 'h43, 'h3C, 'h35},
        '{'h5A, 'h4B, 'h42, 'h3B, 'h33},
        '{'h29, 'h14, 'h3A, 'h31, 'h32}
    };
    int cc[6] = '{'h066, 'h16B, 'h172, 'h175, 'h174, 'h076};
    int cr[6] = '{4, 3, 4, 4, 4, 7};
    int ck[6] = '{0, 4, 4, 3, 2, 0};
`ifdef KEYMATRIX_ESC_BREAK_EN
    int ncomp = 6;
`else
    int ncomp = 5;
`endif

    function automatic bit pressed(input int r, input int k);
        bit p, any;
        p = held[mat[r][k]];
        any = 1'b0;
        for (int i = 0; i < ncomp; i++) begin
            if (held[cc[i]]) begin
                any = 1'b1;
                if (cr[i] == r && ck[i] == k) p = 1'b1;
            end
        end
        if (r == 0 && k == 0) p = p | held['h059] | any;
        if (r == 7 && k == 1) p = p | held['h114];
        return p;
    endfunction

    function automatic logic [8:0] model_out(input logic [7:0] rw);
        logic [4:0] c;
        c = 5'h1F;
        for (int r = 0; r < 8; r++)
            if (!rw[r])
                for (int k = 0; k < 5; k++)
                    if (pressed(r, k)) c[k] = 1'b0;
        return {c, ~held['h005], ~held['h006], ~held['h003], ~held['h001]};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 512; i++) held[i] = 1'b0;
        m_ext = 1'b0;
        m_brk = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clock);
        #1 strb = 1'b1;
        code = b;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            held[{m_ext, b}] = !m_brk;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
        @(posedge clock);
        #1 strb = 1'b0;
    endtask

    task automatic probe(input string nm, input logic [7:0] rw);
        exp_t e;
        @(posedge clock);
        #1 row = rw;
        @(posedge clock);
        #1;
        e.name = nm;
        e.exp  = model_out(rw);
        sbq.push_back(e);
    endtask

    // Reset mid-cycle with a strobe inside it that must be ignored
    task automatic do_reset();
        @(posedge clock);
        #2 reset = 1'b1;
        model_clear();
        strb = 1'b1;
        code = 8'h1C;
        @(posedge clock);
        #1 strb = 1'b0;
        @(posedge clock);
        #2 reset = 1'b0;
    endtask

    always @(negedge clock) begin
        if (sbq.size() > 0) begin
            exp_t e;
            logic [8:0] got;
            e = sbq.pop_front();
            got = {col, play, stop, F5, F9};
            checks++;
            if (got !== e.exp) begin
                errors++;
                $display("FAIL %s row=%h got col/ctl=%h exp=%h",
                         e.name, row, got, e.exp);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    int pool[$];

    initial begin
        reset = 1'b1;
        strb  = 1'b0;
        code  = 8'h00;
        row   = 8'hFF;
        model_clear();
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;

        probe("reset_all", 8'h00);
        send(8'h1C);
        probe("a_make", 8'hFD);
        send(8'hF0); send(8'h1C);
        probe("a_break", 8'hFD);

        send(8'hE0); send(8'h75);
        probe("up_cs", 8'hFE);
        probe("up_7", 8'hEF);
        probe("up_multi", 8'hEE);
        send(8'hE0); send(8'hF0); send(8'h75);
        probe("up_rel", 8'hEE);

        send(8'h12); send(8'h66); send(8'hF0); send(8'h66);
        probe("bksp_cs_kept", 8'hFE);
        probe("bksp_0_rel", 8'hEF);
        send(8'hF0); send(8'h12);
        probe("shift_rel", 8'hFE);

        send(8'h05);
        probe("play_on", 8'hFF);
        send(8'hF0); send(8'h05);
        probe("play_off", 8'hFF);
        send(8'h01);
        probe("f9_on", 8'hFF);
        send(8'hF0); send(8'h01);

        send(8'hE0);
        do_reset();
        probe("rst_all", 8'h00);
        probe("rst_strb", 8'hFD);
        send(8'h14);
        probe("ss_lctrl", 8'h7F);
        send(8'hF0); send(8'h14);
        probe("ss_rel", 8'h7F);

        send(8'h76);
        probe("esc_7f", 8'h7F);
        probe("esc_fe", 8'hFE);
        send(8'h76);
        probe("esc_rep", 8'hFE);
        send(8'hF0); send(8'h76);
        probe("esc_rel", 8'hFE);

        for (int r = 0; r < 8; r++)
            for (int k = 0; k < 5; k++) pool.push_back(mat[r][k]);
        pool.push_back('h59); pool.push_back('h66); pool.push_back('h6B);
        pool.push_back('h72); pool.push_back('h75); pool.push_back('h74);
        pool.push_back('h76); pool.push_back('h01); pool.push_back('h03);
        pool.push_back('h05); pool.push_back('h06); pool.push_back('h77);
        pool.push_back('hE1);
        repeat (8) pool.push_back('hE0);
        repeat (12) pool.push_back('hF0);

        for (int n = 0; n < 500; n++) begin
            int sel;
            logic [7:0] rw;
            sel = $urandom_range(0, 99);
            if (sel < 60) begin
                send(8'(pool[$urandom_range(0, pool.size() - 1)]));
            end else if (sel < 99) begin
                if ($urandom_range(0, 1) == 0)
                    rw = ~(8'h01 << $urandom_range(0, 7));
                else
                    rw = 8'($urandom);
                probe("rand", rw);
            end else begin
                do_reset();
                probe("rand_rst", 8'h00);
            end
        end
        probe("final", 8'h00);

        repeat (4) @(posedge clock);
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d exp=0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
